// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the KGP-RISC datapath.
// Sequences FETCH / DECODE / EXEC / MEM / WB, emits datapath strobes,
// guards memory handshakes with a wait-cycle timeout and counts retired
// instructions. HALT and FAULT are terminal until reset.
module multicycle_control_unit #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [3:0]       fCode,
    input  logic             zero,
    input  logic             sign,
    input  logic             carry,
    input  logic             mem_ready,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             irWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             regWrite,
    output logic [1:0]       wbSel,
    output logic             aluSrc,
    output logic [3:0]       aluOp,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    // Last wait count tolerated; one more idle cycle would exceed MEM_TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic [7:0]       wait_cnt_r;
    logic [CNT_W-1:0] retired_r;
    logic             illegal_s;
    logic             taken_s;
    logic             retire_s;

    // Classify the decoded instruction: legality and branch-taken condition.
    always_comb begin
        illegal_s = 1'b0;
        taken_s   = 1'b0;
        case (opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1111: begin
                illegal_s = 1'b0;
                taken_s   = 1'b0;
            end
            4'b0100, 4'b0110, 4'b0111: begin
                illegal_s = 1'b0;
                taken_s   = 1'b1;
            end
            4'b0101: begin
                case (fCode)
                    4'd0:    taken_s = sign;
                    4'd1:    taken_s = zero;
                    4'd2:    taken_s = ~zero;
                    default: illegal_s = 1'b1;
                endcase
            end
            4'b1000: begin
                case (fCode)
                    4'd0:    taken_s = carry;
                    4'd1:    taken_s = ~carry;
                    default: illegal_s = 1'b1;
                endcase
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state_s = S_FAULT;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = S_FAULT;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (illegal_s) begin
                    next_state_s = S_FAULT;
                end else if (opcode == 4'b1111) begin
                    next_state_s = S_HALT;
                end else begin
                    next_state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    4'b0000, 4'b0001, 4'b0110:          next_state_s = S_WB;
                    4'b0010, 4'b0011:                   next_state_s = S_MEM;
                    4'b0100, 4'b0101, 4'b0111, 4'b1000: next_state_s = S_FETCH;
                    default:                            next_state_s = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    next_state_s = (opcode == 4'b0011) ? S_FETCH : S_WB;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = S_FAULT;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB:    next_state_s = S_FETCH;
            S_HALT:  next_state_s = S_HALT;
            S_FAULT: next_state_s = S_FAULT;
            default: next_state_s = S_FAULT;
        endcase
    end

    // An instruction retires on its last cycle (return to FETCH) or on HALT entry.
    always_comb begin
        if ((state_r != S_FETCH) && (next_state_s == S_FETCH)) begin
            retire_s = 1'b1;
        end else if ((state_r == S_DECODE) && (next_state_s == S_HALT)) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // State register, memory wait counter and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 8'd0;
            retired_r  <= '0;
        end else begin
            state_r <= next_state_s;
            if (((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
            if (retire_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Strobe decode from the current state; reset forces every strobe low at once.
    always_comb begin
        pcWrite  = 1'b0;
        pcSrc    = 2'd0;
        irWrite  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        wbSel    = 2'd0;
        aluSrc   = 1'b0;
        aluOp    = 4'd0;
        halted   = 1'b0;
        fault    = 1'b0;
        if (rst) begin
            pcWrite = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    memRead = 1'b1;
                    irWrite = mem_ready;
                end
                S_DECODE: begin
                    pcWrite = 1'b0;
                end
                S_EXEC: begin
                    aluSrc = (opcode == 4'b0001) || (opcode == 4'b0010) || (opcode == 4'b0011);
                    aluOp  = ((opcode == 4'b0000) || (opcode == 4'b0001)) ? fCode : 4'd0;
                    case (opcode)
                        4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000: begin
                            pcWrite = 1'b1;
                            if (!taken_s) begin
                                pcSrc = 2'd0;
                            end else if (opcode == 4'b0111) begin
                                pcSrc = 2'd2;
                            end else begin
                                pcSrc = 2'd1;
                            end
                        end
                        default: pcWrite = 1'b0;
                    endcase
                end
                S_MEM: begin
                    memRead  = (opcode == 4'b0010);
                    memWrite = (opcode == 4'b0011);
                    pcWrite  = (opcode == 4'b0011) && mem_ready;
                end
                S_WB: begin
                    regWrite = 1'b1;
                    case (opcode)
                        4'b0010: wbSel = 2'd1;
                        4'b0110: wbSel = 2'd2;
                        default: wbSel = 2'd0;
                    endcase
                    // bl already updated the PC during EXEC.
                    pcWrite = (opcode != 4'b0110);
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: fault  = 1'b1;
            endcase
        end
    end

    assign state   = state_r;
    assign retired = retired_r;

endmodule
